exp: RTL and testbench
======================

// Module: exp
// PURPOSE
// - Computes e^x on signed fixed-point data using a truncated Taylor series: sum over n=0..N of x^n/n!.
// - Multi-cycle iterative datapath: one multiplier, one sequential divider, one accumulator.
// - Valid/ready streaming element in the cnn1d datapath; intended feed for softmax-style normalisation.
// PARAMETERS
// - DATA_WIDTH  cnn1d_pkg (12)  sample width; imported from cnn1d_pkg, not overridable.
// - PRECISION   6               fractional bits; ONE = 1<<PRECISION (0x040 at default).
// - TERMS       3               series order N used when EXP_DEBUG_EN is undefined.
// PORTS
// - clk            in   1           single clock, rising edge.
// - rst            in   1           synchronous, active-high reset.
// - exp_ready_in   out  1           block can accept an input sample.
// - exp_valid_in   in   1           exp_data_in is valid.
// - exp_data_in    in   DATA_WIDTH  x, signed two's complement, PRECISION fractional bits.
// - debug_denom    in   DATA_WIDTH  unsigned series order N (used only under EXP_DEBUG_EN).
// - exp_ready_out  in   1           downstream accepts the result.
// - exp_valid_out  out  1           exp_data_out is valid.
// - exp_data_out   out  DATA_WIDTH  e^x, unsigned magnitude, PRECISION fractional bits, MSB always 0.
// BEHAVIOUR
// - Reset: state=IDLE, exp_ready_in=0, exp_valid_out=0, exp_data_out=0. exp_ready_in=1 from the first cycle after reset.
// - Internal width ACC_W=3*DATA_WIDTH. Registers: term, acc, x (sign-extended), n, N.
// - Every ACC_W assignment saturates to +/-(2^(ACC_W-1)-1); nothing wraps.
// - IDLE: exp_ready_in=1.
//   - On exp_valid_in&&exp_ready_in: latch x and N; acc=ONE, term=ONE, n=1; drop exp_ready_in.
//   - Next state: MUL, or OUT if N==0.
// - MUL (1 cycle): term = sat((term*x) >>> PRECISION). The shift is arithmetic (floors). Next state: DIV.
// - DIV (ACC_W cycles): restoring divide |term| by n (unsigned). The quotient takes term's sign, so division truncates toward zero.
// - ADD (1 cycle): term = quotient; acc = sat(acc+term).
//   - If n==N go to OUT; else n=n+1 and go to MUL.
// - OUT: exp_valid_out=1; exp_data_out = clamp(acc, 0, 2^(DATA_WIDTH-1)-1).
//   - Negative acc outputs 0. Overflow outputs 0x7FF.
//   - Data is held stable while exp_ready_out=0.
//   - On exp_ready_out: exp_valid_out=0, go to IDLE; exp_ready_in=1 next cycle.
// - Latency from the accept edge to exp_valid_out high: N*(ACC_W+2)+1 cycles (115 at defaults, N=3). N=0: 1 cycle.
// - Throughput: one sample in flight. No input accepted from the accept edge until the output handshake completes.
// - exp_data_in and N changing after acceptance have no effect on the sample in flight.
// - rst asserted mid-computation or in OUT aborts the sample and returns to the reset state on the next edge.
// CONFIGURATION
// - EXP_DEBUG_EN defined: N = debug_denom sampled at accept (unsigned; 0 gives 1.0). Allows runtime order sweeps.
// - EXP_DEBUG_EN undefined: N = TERMS constant. debug_denom is ignored; the port is kept so the interface is fixed.
// - All other behaviour is identical in both builds.
// TESTING (PRECISION=6, N=3 via debug_denom=3 or TERMS=3)
// - Reset held 3 cycles -> exp_ready_in=0, exp_valid_out=0, exp_data_out=0. exp_ready_in=1 the cycle after release.
// - x=0x000 (0.0) -> exp_data_out=0x040 (1.0) after 115 cycles.
// - x=0x040 (1.0) -> terms 64, 32, 10 -> exp_data_out=0x0AA (2.656).
// - x=0x020 (0.5) -> terms 32, 8, 1 -> exp_data_out=0x069.
// - x=0x044 (1.0625) -> terms 68, 36, 12 -> 0x0B4.
// - x=0x940 (-27.0) -> acc=-188288 -> clamped 0x000.
// - Backpressure: hold exp_ready_out=0 for 20 cycles -> valid/data stable, exp_ready_in=0.
// - Reset mid-DIV -> back to IDLE with no output produced.

Source files
------------

// File: rtl/exp.sv
// exp: e^x on signed fixed-point samples via a truncated Taylor series (one multiplier, serial divider).
// Build option: define EXP_DEBUG_EN to take the series order from debug_denom at accept time.

package cnn1d_pkg;
  localparam int DATA_WIDTH = 12;
endpackage

module exp
  import cnn1d_pkg::*;
#(
  parameter int PRECISION = 6,
  parameter int TERMS     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  exp_ready_in,
  input  logic                  exp_valid_in,
  input  logic [DATA_WIDTH-1:0] exp_data_in,
  input  logic [DATA_WIDTH-1:0] debug_denom,
  input  logic                  exp_ready_out,
  output logic                  exp_valid_out,
  output logic [DATA_WIDTH-1:0] exp_data_out
);

  localparam int ACC_W = 3 * DATA_WIDTH;
  localparam int CNT_W = $clog2(ACC_W);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(ACC_W - 1);
  localparam logic signed [ACC_W-1:0] ONE = ACC_W'(2 ** PRECISION);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [2*ACC_W-1:0] WIDE_MAX = {{(ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, MUL, DIV, ADD, OUT} state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  x_reg;
  logic [DATA_WIDTH-1:0]    n;
  logic [DATA_WIDTH-1:0]    n_max;
  logic [ACC_W-1:0]         rem;
  logic [ACC_W-1:0]         quo;
  logic                     div_neg;
  logic [CNT_W-1:0]         cnt;

  logic [DATA_WIDTH-1:0]    n_accept;
  logic signed [2*ACC_W-1:0] prod_full;
  logic signed [ACC_W-1:0]  prod_sat;
  logic signed [ACC_W-1:0]  prod_neg;
  logic [ACC_W-1:0]         prod_mag;
  logic [ACC_W:0]           trial;
  logic [ACC_W:0]           divisor;
  logic [ACC_W:0]           diff;
  logic                     trial_ge;
  logic signed [ACC_W-1:0]  quot;
  logic [ACC_W:0]           sum_full;
  logic signed [ACC_W-1:0]  sum_sat;
  logic [DATA_WIDTH-1:0]    clamp_val;

  // Every internal result is clipped symmetrically so that nothing wraps.
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [2*ACC_W-1:0] v);
    if (v > WIDE_MAX)
      return SAT_MAX;
    else if (v < -WIDE_MAX)
      return -SAT_MAX;
    else
      return v[ACC_W-1:0];
  endfunction

`ifdef EXP_DEBUG_EN
  assign n_accept = debug_denom;
`else
  logic unused_debug;
  assign n_accept     = DATA_WIDTH'(TERMS);
  assign unused_debug = ^debug_denom;
`endif

  assign prod_full = $signed({{ACC_W{term[ACC_W-1]}}, term}) *
                     $signed({{ACC_W{x_reg[ACC_W-1]}}, x_reg});
  assign prod_sat  = sat(prod_full >>> PRECISION);
  assign prod_neg  = -prod_sat;
  assign prod_mag  = prod_sat[ACC_W-1] ? prod_neg : prod_sat;

  // Restoring divide step: the borrow out of the trial subtraction decides the quotient bit.
  assign trial    = {rem, quo[ACC_W-1]};
  assign divisor  = {{(ACC_W-DATA_WIDTH+1){1'b0}}, n};
  assign diff     = trial - divisor;
  assign trial_ge = ~diff[ACC_W];

  assign quot     = div_neg ? -$signed(quo) : $signed(quo);
  assign sum_full = {acc[ACC_W-1], acc} + {quot[ACC_W-1], quot};
  assign sum_sat  = sat($signed({{(ACC_W-1){sum_full[ACC_W]}}, sum_full}));

  always_comb begin
    clamp_val = {1'b0, acc[DATA_WIDTH-2:0]};
    if (acc[ACC_W-1])
      clamp_val = '0;
    else if (|acc[ACC_W-2:DATA_WIDTH-1])
      clamp_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      exp_ready_in  <= 1'b0;
      exp_valid_out <= 1'b0;
      exp_data_out  <= '0;
      term          <= '0;
      acc           <= '0;
      x_reg         <= '0;
      n             <= '0;
      n_max         <= '0;
      rem           <= '0;
      quo           <= '0;
      div_neg       <= 1'b0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (exp_valid_in && exp_ready_in) begin
            x_reg        <= {{(ACC_W-DATA_WIDTH){exp_data_in[DATA_WIDTH-1]}}, exp_data_in};
            n_max        <= n_accept;
            acc          <= ONE;
            term         <= ONE;
            n            <= DATA_WIDTH'(1);
            exp_ready_in <= 1'b0;
            state        <= (n_accept == '0) ? OUT : MUL;
          end else begin
            exp_ready_in <= 1'b1;
          end
        end
        MUL: begin
          term    <= prod_sat;
          quo     <= prod_mag;
          rem     <= '0;
          div_neg <= prod_sat[ACC_W-1];
          cnt     <= '0;
          state   <= DIV;
        end
        DIV: begin
          quo <= {quo[ACC_W-2:0], trial_ge};
          rem <= trial_ge ? diff[ACC_W-1:0] : trial[ACC_W-1:0];
          cnt <= cnt + CNT_W'(1);
          if (cnt == DIV_LAST)
            state <= ADD;
        end
        ADD: begin
          term <= quot;
          acc  <= sum_sat;
          if (n == n_max) begin
            state <= OUT;
          end else begin
            n     <= n + DATA_WIDTH'(1);
            state <= MUL;
          end
        end
        // First OUT cycle presents the clamped result; it then holds until taken.
        OUT: begin
          if (!exp_valid_out) begin
            exp_valid_out <= 1'b1;
            exp_data_out  <= clamp_val;
          end else if (exp_ready_out) begin
            exp_valid_out <= 1'b0;
            exp_ready_in  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp.sv
// Scoreboard bench for exp: a plain-arithmetic Taylor-series model predicts each result,
// a separate monitor checks results, latency, hold stability and busy behaviour.
module tb_exp;

  localparam int     DW      = 12;
  localparam int     N_TERMS = 3;
  localparam int     PREC    = 6;
  localparam int     LATENCY = N_TERMS * (3 * DW + 2) + 1;
  localparam longint SAT_LIM = 64'sh7_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          exp_ready_in;
  logic          exp_valid_in;
  logic [DW-1:0] exp_data_in;
  logic [DW-1:0] debug_denom;
  logic          exp_ready_out;
  logic          exp_valid_out;
  logic [DW-1:0] exp_data_out;

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] data;
    int            accept_cycle;
  } exp_t;

  exp_t          sb[$];
  exp_t          cur;
  int            tests      = 0;
  int            failures   = 0;
  int            cycle      = 0;
  int            bp_mode    = 0;
  int            valid_seen = 0;
  logic          seen_valid = 1'b0;
  logic [DW-1:0] held_data  = '0;
  logic [DW-1:0] directed [7] = '{12'h000, 12'h040, 12'h020, 12'h044, 12'h940, 12'h7FF, 12'h800};

  exp dut (
    .clk          (clk),
    .rst          (rst),
    .exp_ready_in (exp_ready_in),
    .exp_valid_in (exp_valid_in),
    .exp_data_in  (exp_data_in),
    .debug_denom  (debug_denom),
    .exp_ready_out(exp_ready_out),
    .exp_valid_out(exp_valid_out),
    .exp_data_out (exp_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic longint satl(input longint v);
    if (v > SAT_LIM) return SAT_LIM;
    if (v < -SAT_LIM) return -SAT_LIM;
    return v;
  endfunction

  // Reference: sum of x^n/n! built term by term, each term floored after scaling and truncated by n.
  function automatic logic [DW-1:0] refExp(input logic [DW-1:0] xr);
    longint x, term, acc;
    x    = longint'($signed(xr));
    term = 64'sd1 <<< PREC;
    acc  = term;
    for (int n = 1; n <= N_TERMS; n++) begin
      term = satl((term * x) >>> PREC);
      term = term / n;
      acc  = satl(acc + term);
    end
    if (acc < 0) return '0;
    if (acc > 2047) return 12'h7FF;
    return DW'(acc);
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] x);
    int waited = 0;
    while (!exp_ready_in && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("ready_in_before_accept", exp_ready_in, 1);
    if (exp_ready_in) begin
      exp_valid_in = 1'b1;
      exp_data_in  = x;
      @(posedge clk); #1;
      sb.push_back('{x: x, data: refExp(x), accept_cycle: cycle});
      exp_valid_in = 1'b0;
      exp_data_in  = DW'($urandom);
    end
  endtask

  task automatic waitDrain();
    int waited = 0;
    while (sb.size() != 0 && waited < 5000) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic waitValid();
    int waited = 0;
    while (!exp_valid_out && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("valid_out_arrives", exp_valid_out, 1);
  endtask

  // Downstream ready: always on, random stalls, or held low.
  initial begin
    exp_ready_out = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (bp_mode)
        0:       exp_ready_out = 1'b1;
        1:       exp_ready_out = ($urandom_range(0, 3) != 0);
        default: exp_ready_out = 1'b0;
      endcase
    end
  end

  // Monitor: compares against the scoreboard independently of the stimulus process.
  always @(negedge clk) begin
    if (rst) begin
      seen_valid = 1'b0;
    end else if (exp_valid_out) begin
      valid_seen++;
      checkOutput("ready_in_while_busy", exp_ready_in, 0);
      if (!seen_valid) begin
        seen_valid = 1'b1;
        held_data  = exp_data_out;
        if (sb.size() == 0)
          checkOutput("unexpected_output", sb.size(), 1);
        else
          checkOutput("latency", cycle - sb[0].accept_cycle, LATENCY);
      end else begin
        checkOutput("hold_data", exp_data_out, held_data);
      end
      if (exp_ready_out) begin
        seen_valid = 1'b0;
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          checkOutput($sformatf("data x=%03h", cur.x), exp_data_out, cur.data);
        end
      end
    end
  end

  initial begin
    rst          = 1'b1;
    exp_valid_in = 1'b0;
    exp_data_in  = '0;
    debug_denom  = DW'(N_TERMS);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready_in", exp_ready_in, 0);
    checkOutput("reset_valid_out", exp_valid_out, 0);
    checkOutput("reset_data_out", exp_data_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", exp_ready_in, 1);

    foreach (directed[i]) applyStimulus(directed[i]);

    bp_mode = 1;
    repeat (25) applyStimulus(DW'($urandom_range(0, 4095)));
    waitDrain();

    // Held backpressure: result must stay put and no new input accepted.
    bp_mode = 2;
    applyStimulus(12'h040);
    waitValid();
    repeat (20) @(posedge clk);
    #1;
    checkOutput("bp_valid_held", exp_valid_out, 1);
    checkOutput("bp_ready_in_low", exp_ready_in, 0);
    bp_mode = 0;
    waitDrain();

    // Abort a sample in the middle of its first divide.
    applyStimulus(12'h020);
    repeat (20) @(posedge clk);
    #1;
    sb.delete();
    valid_seen = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_ready_in", exp_ready_in, 0);
    checkOutput("abort_valid_out", exp_valid_out, 0);
    checkOutput("abort_data_out", exp_data_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_ready_after", exp_ready_in, 1);
    repeat (150) @(posedge clk);
    #1;
    checkOutput("abort_no_output", valid_seen, 0);

    applyStimulus(12'h044);
    applyStimulus(DW'($urandom_range(0, 4095)));
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
